// File: rtl/crosscorr_prod_accum.sv
// Frame accumulator for cross-correlation products: sums a frame of signed products, rounds,
// shifts and emits one result per frame. Define CROSSCORR_ACC_SAT_EN to clamp instead of wrap.
module crosscorr_prod_accum #(
   parameter int unsigned DIN_WIDTH  = 56,
   parameter int unsigned DOUT_WIDTH = 31,
   parameter int unsigned CNT_WIDTH  = 10,
   parameter int unsigned SHIFT      = 25
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [CNT_WIDTH-1:0]  frame_len,
   input  logic [DIN_WIDTH-1:0]  din,
   input  logic                  din_vld,
   output logic                  in_rdy,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  dout_vld,
   input  logic                  dout_rdy,
   output logic                  sat
);

   localparam int unsigned AccWidth = DIN_WIDTH + CNT_WIDTH;
   localparam int unsigned SumWidth = AccWidth + 1;
   localparam logic [SumWidth-1:0] RoundBias = SumWidth'(1) << (SHIFT - 1);

   typedef enum logic [0:0] {StIdle, StAccum} state_e;

   state_e                     state_q, state_d;
   logic signed [AccWidth-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0]       count_q, count_d;
   logic [CNT_WIDTH-1:0]       len_q, len_d;
   logic [DOUT_WIDTH-1:0]      dout_q, dout_d;
   logic                       dout_vld_q, dout_vld_d;
   logic                       sat_q, sat_d;

   logic                       accept;
   logic                       last;
   logic [CNT_WIDTH-1:0]       first_len;
   logic [CNT_WIDTH-1:0]       count_inc;
   logic signed [AccWidth-1:0] din_ext;
   logic signed [SumWidth-1:0] sum;
   logic signed [SumWidth-1:0] rounded;
   logic [DOUT_WIDTH-1:0]      result;
   logic                       result_sat;

   assign in_rdy    = !dout_vld_q || dout_rdy;
   assign accept    = din_vld && in_rdy && !clear;
   assign first_len = (frame_len == '0) ? CNT_WIDTH'(1) : frame_len;
   assign count_inc = count_q + 1'b1;

   // In idle the frame length is taken live from the port; once accumulating, the latched copy.
   assign last = (state_q == StIdle) ? (first_len == CNT_WIDTH'(1)) : (count_inc == len_q);

   assign din_ext = {{CNT_WIDTH{din[DIN_WIDTH-1]}}, din};
   assign sum     = {acc_q[AccWidth-1], acc_q} + {din_ext[AccWidth-1], din_ext};
   assign rounded = sum + RoundBias;

`ifdef CROSSCORR_ACC_SAT_EN
   logic signed [SumWidth-1:0] shifted;
   logic                       overflow;

   assign shifted  = rounded >>> SHIFT;
   // Out of range whenever the bits above the result sign disagree with the true sign.
   assign overflow = shifted[SumWidth-1:DOUT_WIDTH-1]
                     != {(SumWidth - DOUT_WIDTH + 1){shifted[SumWidth-1]}};

   always_comb begin
      result     = shifted[DOUT_WIDTH-1:0];
      result_sat = 1'b0;
      if (overflow) begin
         result_sat = 1'b1;
         result     = shifted[SumWidth-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      end
   end
`else
   assign result     = DOUT_WIDTH'(rounded >>> SHIFT);
   assign result_sat = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      count_d    = count_q;
      len_d      = len_q;
      dout_d     = dout_q;
      dout_vld_d = dout_vld_q;
      sat_d      = sat_q;

      if (dout_vld_q && dout_rdy) begin
         dout_vld_d = 1'b0;
      end

      if (clear) begin
         state_d = StIdle;
         acc_d   = '0;
         count_d = '0;
      end else if (accept) begin
         if (last) begin
            state_d    = StIdle;
            acc_d      = '0;
            count_d    = '0;
            dout_d     = result;
            sat_d      = result_sat;
            dout_vld_d = 1'b1;
         end else begin
            acc_d = sum[AccWidth-1:0];
            if (state_q == StIdle) begin
               state_d = StAccum;
               len_d   = first_len;
               count_d = CNT_WIDTH'(1);
            end else begin
               count_d = count_inc;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         count_q    <= '0;
         len_q      <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         len_q      <= len_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         sat_q      <= sat_d;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign sat      = sat_q;

endmodule

// File: tb/tb_crosscorr_prod_accum.sv
// Randomized and directed bench for crosscorr_prod_accum against a frame-level reference model.
// Define CROSSCORR_ACC_SAT_EN here as well as in the RTL build to check the clamping variant.
module tb_crosscorr_prod_accum;

   localparam int DinW  = 56;
   localparam int DoutW = 31;
   localparam int CntW  = 10;
   localparam int Shift = 25;

   localparam longint P24 = 64'sd1 <<< 24;
   localparam longint P25 = 64'sd1 <<< 25;
   localparam longint P54 = 64'sd1 <<< 54;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             clear = 1'b0;
   logic [CntW-1:0]  frame_len = '0;
   logic [DinW-1:0]  din = '0;
   logic             din_vld = 1'b0;
   logic             in_rdy;
   logic [DoutW-1:0] dout;
   logic             dout_vld;
   logic             dout_rdy = 1'b0;
   logic             sat;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: samples of the open frame plus the held result.
   longint           frame_q[$];
   int               m_len = 1;
   logic             m_vld = 1'b0;
   logic [DoutW-1:0] m_dout = '0;
   logic             m_sat = 1'b0;

   crosscorr_prod_accum #(
      .DIN_WIDTH (DinW),
      .DOUT_WIDTH(DoutW),
      .CNT_WIDTH (CntW),
      .SHIFT     (Shift)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .frame_len(frame_len),
      .din      (din),
      .din_vld  (din_vld),
      .in_rdy   (in_rdy),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_result(input longint s, output logic [DoutW-1:0] d,
                                      output logic st);
      longint r;
      longint hi;
      longint lo;
      r  = (s + (64'sd1 <<< (Shift - 1))) >>> Shift;
      hi = (64'sd1 <<< (DoutW - 1)) - 1;
      lo = -(64'sd1 <<< (DoutW - 1));
      st = 1'b0;
`ifdef CROSSCORR_ACC_SAT_EN
      if (r > hi) begin
         d  = hi[DoutW-1:0];
         st = 1'b1;
      end else if (r < lo) begin
         d  = lo[DoutW-1:0];
         st = 1'b1;
      end else begin
         d = r[DoutW-1:0];
      end
`else
      d = r[DoutW-1:0];
      if (hi < lo) st = 1'b1;
`endif
   endfunction

   task automatic compare_outputs();
      check_eq("in_rdy", in_rdy, !m_vld || dout_rdy);
      check_eq("dout_vld", dout_vld, m_vld);
      if (m_vld) begin
         check_eq("dout", dout, m_dout);
         check_eq("sat", sat, m_sat);
      end
   endtask

   // Advances the model across the upcoming rising edge using the inputs now applied.
   task automatic model_update();
      logic   take;
      longint s;
      take = din_vld && (!m_vld || dout_rdy) && !clear;
      if (m_vld && dout_rdy) m_vld = 1'b0;
      if (clear) begin
         frame_q.delete();
      end else if (take) begin
         if (frame_q.size() == 0) m_len = (frame_len == '0) ? 1 : int'(frame_len);
         frame_q.push_back(longint'($signed(din)));
         if (frame_q.size() == m_len) begin
            s = 0;
            foreach (frame_q[i]) s += frame_q[i];
            ref_result(s, m_dout, m_sat);
            m_vld = 1'b1;
            frame_q.delete();
         end
      end
   endtask

   task automatic step(input int unsigned len, input logic v, input longint d, input logic r,
                       input logic c);
      @(negedge clk);
      frame_len = len[CntW-1:0];
      din_vld   = v;
      din       = d[DinW-1:0];
      dout_rdy  = r;
      clear     = c;
      #1;
      compare_outputs();
      model_update();
   endtask

   // Checks the registered result right after the edge that accepts the last sample.
   task automatic expect_out(input string tag, input logic [DoutW-1:0] exp_d,
                             input logic exp_s);
      @(posedge clk);
      #1;
      check_eq({tag, "_vld"}, dout_vld, 1'b1);
      check_eq({tag, "_dout"}, dout, exp_d);
      check_eq({tag, "_sat"}, sat, exp_s);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      din_vld = 1'b0;
      clear   = 1'b0;
      #1;
      check_eq("rst_in_rdy", in_rdy, 1'b1);
      check_eq("rst_dout_vld", dout_vld, 1'b0);
      check_eq("rst_dout", dout, '0);
      check_eq("rst_sat", sat, 1'b0);
      frame_q.delete();
      m_vld  = 1'b0;
      m_dout = '0;
      m_sat  = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic flush();
      step(1, 1'b0, 0, 1'b1, 1'b0);
   endtask

   initial begin
      longint v;
      logic [DoutW-1:0] big_d;
      logic big_s;

      apply_reset();

      // Four contiguous samples of 2^25.
      for (int i = 0; i < 4; i++) step(4, 1'b1, P25, 1'b1, 1'b0);
      expect_out("len4", 31'd4, 1'b0);

      // Single-sample frames exercise round-half-up on both signs.
      step(1, 1'b1, P24, 1'b1, 1'b0);
      expect_out("half_pos", 31'd1, 1'b0);
      step(1, 1'b1, -P24, 1'b1, 1'b0);
      expect_out("half_neg", 31'd0, 1'b0);
      step(1, 1'b1, -(P24 + 1), 1'b1, 1'b0);
      expect_out("below_half", 31'h7FFF_FFFF, 1'b0);

      // Result one step past the positive range.
`ifdef CROSSCORR_ACC_SAT_EN
      big_d = 31'h3FFF_FFFF;
      big_s = 1'b1;
`else
      big_d = 31'h4000_0000;
      big_s = 1'b0;
`endif
      step(2, 1'b1, P54, 1'b1, 1'b0);
      step(2, 1'b1, P54, 1'b1, 1'b0);
      expect_out("range", big_d, big_s);

      // Held result stalls the input; release and a new sample land in the same cycle.
      flush();
      step(1, 1'b1, P25, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1'b1, 7 * P25, 1'b0, 1'b0);
         check_eq("stall_in_rdy", in_rdy, 1'b0);
         check_eq("stall_dout", dout, 31'd1);
      end
      step(1, 1'b1, 3 * P25, 1'b1, 1'b0);
      expect_out("resume", 31'd3, 1'b0);

      // Reset mid-frame discards the partial frame.
      flush();
      step(3, 1'b1, P25, 1'b1, 1'b0);
      step(3, 1'b1, P25, 1'b1, 1'b0);
      apply_reset();
      for (int i = 0; i < 3; i++) step(3, 1'b1, P25, 1'b1, 1'b0);
      expect_out("after_rst", 31'd3, 1'b0);

      // Clear mid-frame does the same and ignores din in its own cycle.
      flush();
      step(3, 1'b1, P25, 1'b1, 1'b0);
      step(3, 1'b1, 9 * P25, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(3, 1'b1, P25, 1'b1, 1'b0);
      expect_out("after_clr", 31'd3, 1'b0);

      // Zero length behaves as one; bubbles carry garbage that must not be summed.
      flush();
      step(0, 1'b1, 5 * P25, 1'b1, 1'b0);
      expect_out("len0", 31'd5, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(4, 1'b0, 11 * P25, 1'b1, 1'b0);
         step(4, 1'b1, P25, 1'b1, 1'b0);
      end
      expect_out("bubbles", 31'd4, 1'b0);

      // Random traffic: varying lengths (changed mid-frame), bubbles, back-pressure, clears.
      flush();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) == 0) v = longint'($signed({$urandom, $urandom})) >>> 9;
         else v = longint'($signed({$urandom, $urandom})) >>> 23;
         step($urandom_range(0, 5), 1'($urandom_range(0, 3) != 0), v,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
      end
      step(1, 1'b0, 0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/crosscorr_prod_accum.md
CROSSCORR_PROD_ACCUM -- requirements
Module: crosscorr_prod_accum

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 56: signed product width from the upstream multiplier.
REQ-002 SHALL have parameter DOUT_WIDTH, default 31: signed result width.
REQ-003 SHALL have parameter CNT_WIDTH, default 10: frame-length counter width.
REQ-004 SHALL have parameter SHIFT, default 25, legal range 1..DIN_WIDTH-1: right-shift applied to the sum.
REQ-005 SHALL have port clk, input, 1: the only clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1: synchronous frame abort.
REQ-008 SHALL have port frame_len, input, CNT_WIDTH: products per frame.
REQ-009 SHALL have port din, input, DIN_WIDTH: signed product.
REQ-010 SHALL have port din_vld, input, 1: din qualifier.
REQ-011 SHALL have port in_rdy, output, 1: accept and stall; drives the upstream multiplier ce.
REQ-012 SHALL have port dout, output, DOUT_WIDTH: signed frame result.
REQ-013 SHALL have port dout_vld, output, 1: result valid.
REQ-014 SHALL have port dout_rdy, input, 1: consumer ready.
REQ-015 SHALL have port sat, output, 1: set when the result was clipped; qualified by dout_vld.

Function
REQ-016 SHALL define acceptance as din_vld && in_rdy in the same cycle.
REQ-017 SHALL drive in_rdy = !dout_vld || dout_rdy, combinationally.
REQ-018 SHALL implement FSM IDLE/ACCUM: IDLE->ACCUM on an accepted sample when the latched length is >1; ACCUM->IDLE on the accepted sample whose count equals the length.
REQ-019 SHALL latch frame_len on the first accepted sample of a frame and treat a value of 0 as 1; changes to frame_len mid-frame SHALL be ignored.
REQ-020 SHALL sign-extend products into an accumulator of DIN_WIDTH+CNT_WIDTH bits that never wraps.
REQ-021 SHALL, on the last accepted sample, form sum = acc + din, add 2^(SHIFT-1), and arithmetic-shift right by SHIFT (round half up).
REQ-022 SHALL register that shifted result to dout with dout_vld=1 one cycle after the last sample is accepted, and SHALL clear acc/count in that same cycle.
REQ-023 SHALL hold dout, dout_vld and sat stable until dout_vld && dout_rdy; dout_vld SHALL drop the next cycle unless a new result loads simultaneously.
REQ-024 SHALL allow a new frame to accumulate while a result is held, subject only to in_rdy.
REQ-025 SHALL, on clear=1, zero acc/count, return the FSM to IDLE and ignore din that cycle, leaving a held output untouched; clear SHALL take priority over acceptance.
REQ-026 SHALL neither accumulate nor count while din_vld=0 (bubbles allowed anywhere in a frame).

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force FSM=IDLE, acc=0, count=0, dout=0, dout_vld=0, sat=0; in_rdy therefore reads 1.
REQ-028 SHALL, on reset mid-frame, discard the partial frame; the first accepted sample after release starts a new frame.

Configuration
REQ-029 SHALL, with macro CROSSCORR_ACC_SAT_EN defined, clamp the shifted result to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] and set sat=1 when clipping occurs.
REQ-030 SHALL, without CROSSCORR_ACC_SAT_EN, truncate the shifted result to its low DOUT_WIDTH bits (two's-complement wrap) with sat tied to 0.

Verification
REQ-031 SHALL cover frame_len=4, din=2^25 x4 contiguous -> dout=4 one cycle after the 4th sample, sat=0.
REQ-032 SHALL cover frame_len=1: din=2^24 -> dout=1; din=-2^24 -> dout=0; din=-(2^24+1) -> dout=-1.
REQ-033 SHALL cover frame_len=2, din=2^54 x2: with the macro -> dout=0x3FFFFFFF, sat=1; without it -> dout=0x40000000, sat=0.
REQ-034 SHALL cover dout_rdy=0 with result held: in_rdy=0, further din ignored and dout stable; dout_rdy=1 -> handshake, then accumulation resumes with no sample lost.
REQ-035 SHALL cover frame_len=3: reset_n pulsed low after 2 samples, then 3 samples of 2^25 -> dout=3; clear after 1 sample gives the same result.
REQ-036 SHALL cover frame_len=0 with din=5*2^25 -> dout=5 (0 treated as 1), with din_vld bubbles not altering any result.
